// File: rtl/fft_cfg_if.sv
// AXI-Stream configuration channel between fft_cfg_streamer and the FFT core.
// The streamer drives it through the master modport; the core sees the slave side.
interface fft_cfg_if #(
    parameter int CFG_W = 24
);
    logic [CFG_W-1:0] tdata;
    logic             tvalid;
    logic             tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/fft_cfg_streamer.sv
// Sends one FFT config beat whenever {cfg_data_sel, frame_size} changes, holding off the
// sample feeder until the core has re-armed. Optional SEND timeout: define FFT_CFG_TIMEOUT_EN.
module fft_cfg_streamer #(
    parameter int CFG_W       = 24,
    parameter int SETTLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [CFG_W-1:0] cfg_data_sel,
    input  logic [9:0]       frame_size,
    input  logic             data_active,
    fft_cfg_if.master        m_axis_config,
    output logic             cfg_busy,
    output logic [9:0]       applied_frame_size,
    output logic             cfg_done,
    output logic             cfg_timeout
);

    localparam int SNAP_W = CFG_W + 10;
    localparam int SET_W  = $clog2(SETTLE_CYC + 1);

    if (SETTLE_CYC < 1 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("fft_cfg_streamer: SETTLE_CYC and TIMEOUT_CYC must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FRAME,
        SEND,
        SETTLE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CFG_W-1:0]   tdata_r;
    logic [9:0]         size_snap;
    logic [SNAP_W-1:0]  sent_reg;
    logic [SET_W-1:0]   settle_cnt;
    logic               changed;
    logic               handshake;
    logic               latch_en;
    logic               settle_end;
    logic               timeout_hit;
    logic               tvalid_c;

    // Compared against what the core actually accepted, not against the last latch.
    assign changed    = ({cfg_data_sel, frame_size} != sent_reg);
    assign handshake  = (state == SEND) && m_axis_config.tready;
    assign latch_en   = (state == WAIT_FRAME) && !data_active;
    assign settle_end = (state == SETTLE) && (settle_cnt == '0);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= WAIT_FRAME;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: defaults come first so no path through the case leaves an output unassigned (no latch).
    always_comb begin
        state_nxt = state;
        tvalid_c  = 1'b0;
        cfg_busy  = 1'b1;
        unique case (state)
            IDLE: begin
                cfg_busy = 1'b0;
                if (changed) state_nxt = WAIT_FRAME;
            end
            WAIT_FRAME: begin
                if (!data_active) state_nxt = SEND;
            end
            SEND: begin
                tvalid_c = 1'b1;
                if (handshake) begin
                    state_nxt = SETTLE;
                end else if (timeout_hit) begin
                    state_nxt = WAIT_FRAME;
                end
            end
            SETTLE: begin
                if (settle_cnt == '0) state_nxt = changed ? WAIT_FRAME : IDLE;
            end
            default: state_nxt = WAIT_FRAME;
        endcase
    end

    assign m_axis_config.tvalid = tvalid_c;
    assign m_axis_config.tdata  = tdata_r;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tdata_r            <= '0;
            size_snap          <= 10'd512;
            sent_reg           <= '0;
            applied_frame_size <= 10'd512;
            settle_cnt         <= '0;
            cfg_done           <= 1'b0;
        end else begin
            // Registered so the pulse coincides with the first IDLE cycle.
            cfg_done <= settle_end && !changed;

            if (latch_en) begin
                tdata_r   <= cfg_data_sel;
                size_snap <= frame_size;
            end

            if (handshake) begin
                sent_reg           <= {tdata_r, size_snap};
                applied_frame_size <= size_snap;
                settle_cnt         <= SET_W'(SETTLE_CYC - 1);
            end else if ((state == SETTLE) && (settle_cnt != '0)) begin
                settle_cnt <= settle_cnt - 1'b1;
            end
        end
    end

`ifdef FFT_CFG_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] to_cnt;
    logic            timeout_flag;

    // to_cnt counts completed SEND cycles; it is zero on the first SEND cycle.
    assign timeout_hit = (state == SEND) && !m_axis_config.tready &&
                         (to_cnt == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            to_cnt       <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if (state != SEND) begin
                to_cnt <= '0;
            end else if (!timeout_hit) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (timeout_hit) timeout_flag <= 1'b1;
        end
    end

    assign cfg_timeout = timeout_flag;
`else
    assign timeout_hit = 1'b0;
    assign cfg_timeout = 1'b0;
`endif

endmodule
